// File: rtl/booth_pkg.sv
// booth_pkg: shared Booth digit encoding, FSM states and digit-count helper.
package booth_pkg;
    typedef enum logic [2:0] {BD_ZERO, BD_P1, BD_P2, BD_M1, BD_M2} bdigit_e;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
    function automatic int n_digits(input int w);
        return w / 2 + 1;
    endfunction
endpackage

// File: rtl/booth_r4_pp.sv
// booth_r4_pp: recodes one radix-4 window and forms the unshifted partial product.
module booth_r4_pp
    import booth_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2:0]     win_i,
    input  logic [W+1:0]   mx_ext_i,
    output logic [2:0]     digit_o,
    output logic [2*W+1:0] pp_o
);
    bdigit_e dig;
    logic neg;
    logic [2*W+1:0] mag, sel;
    always_comb begin
        dig = (win_i == 3'b001 || win_i == 3'b010) ? BD_P1 :
              (win_i == 3'b011) ? BD_P2 :
              (win_i == 3'b100) ? BD_M2 :
              (win_i == 3'b101 || win_i == 3'b110) ? BD_M1 : BD_ZERO;
        mag = {{W{mx_ext_i[W+1]}}, mx_ext_i};
        sel = (dig == BD_P1 || dig == BD_M1) ? mag :
              (dig == BD_P2 || dig == BD_M2) ? mag << 1 : '0;
        neg = dig == BD_M1 || dig == BD_M2;
        // Negation by invert plus carry-in, so a zero digit never injects a carry.
        pp_o = (sel ^ {(2*W+2){neg}}) + (2*W+2)'(neg);
    end
    assign digit_o = dig;
endmodule

// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult: multi-cycle radix-4 Booth multiplier, PPC digits per cycle,
// signed/unsigned per operation, valid/ready on both sides.
module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int W   = 32,
    parameter int PPC = 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   mx,
    input  logic [W-1:0]   my,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product
);
    localparam int N  = n_digits(W);
    localparam int C  = (N + PPC - 1) / PPC;
    localparam int CW = $clog2(C + 1);

    state_e state_q, state_d;
    logic [W+1:0] mx_q, my_q;
    logic [2*W+1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q;
    logic [2*W-1:0] prod_q;
    logic [W+2:0] ypad;
    logic [2*W+1:0] term [PPC];
    logic last;

    // Bit 0 of ypad is the implicit y[-1] = 0 of the first Booth window.
    assign ypad = {my_q, 1'b0};
    assign last = cnt_q == CW'(C - 1);

    for (genvar j = 0; j < PPC; j++) begin : g_pp
        logic [31:0] idx;
        logic [2:0] win, dig;
        logic [2*W+1:0] pp;
        assign idx = 32'(cnt_q) * 32'(PPC) + 32'(j);
        assign win = 3'(ypad >> {idx[30:0], 1'b0});
        booth_r4_pp #(.W(W)) u_pp (
            .win_i    (win),
            .mx_ext_i (mx_q),
            .digit_o  (dig),
            .pp_o     (pp)
        );
        // Digits past the last one exist only when PPC does not divide N.
        assign term[j] = (idx < 32'(N) && dig != BD_ZERO) ? pp << {idx[30:0], 1'b0} : '0;
    end

    always_comb begin
        acc_d = acc_q;
        for (int k = 0; k < PPC; k++) acc_d = acc_d + term[k];
    end

    always_comb begin
        state_d = state_q;
        state_d = (state_q == S_IDLE && in_valid)  ? S_RUN  :
                  (state_q == S_RUN && last)       ? S_DONE :
                  (state_q == S_DONE && out_ready) ? S_IDLE : state_q;
    end

    assign in_ready  = state_q == S_IDLE;
    assign out_valid = state_q == S_DONE;
    assign product   = prod_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            mx_q    <= '0;
            my_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && in_valid) begin
                mx_q  <= is_signed ? {{2{mx[W-1]}}, mx} : {2'b00, mx};
                my_q  <= is_signed ? {{2{my[W-1]}}, my} : {2'b00, my};
                acc_q <= '0;
                cnt_q <= '0;
            end else if (state_q == S_RUN) begin
                acc_q <= acc_d;
                cnt_q <= cnt_q + CW'(1);
                if (last) prod_q <= acc_d[2*W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb_booth_r4_seq_mult: directed vectors, handshake corner cases and sweeps
// on a W=32/PPC=1 instance and a W=8/PPC=2 instance.
module tb_booth_r4_seq_mult;
    logic CLK = 0, RST = 1;
    always #5 CLK = ~CLK;

    logic in_valid = 0, in_ready, is_signed = 0, out_valid, out_ready = 0;
    logic [31:0] mx = 0, my = 0;
    logic [63:0] product;
    logic b_in_valid = 0, b_in_ready, b_sgn = 0, b_out_valid, b_out_ready = 0;
    logic [7:0] b_mx = 0, b_my = 0;
    logic [15:0] b_prod;
    int n_chk = 0, n_fail = 0;

    booth_r4_seq_mult #(.W(32), .PPC(1)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .mx(mx), .my(my), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .product(product)
    );

    booth_r4_seq_mult #(.W(8), .PPC(2)) dut_b (
        .CLK(CLK), .RST(RST), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .mx(b_mx), .my(b_my), .is_signed(b_sgn), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .product(b_prod)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] p;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input int gap, output logic [63:0] got, output int lat);
        @(negedge CLK);
        chk("in_ready_pre", in_ready, 1);
        mx = a; my = b; is_signed = s; in_valid = 1;
        @(posedge CLK); #1 in_valid = 0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge CLK); #1 lat++;
        end
        got = product;
        repeat (gap) begin
            @(posedge CLK); #1;
        end
        @(negedge CLK); out_ready = 1;
        @(posedge CLK); #1 out_ready = 0;
    endtask

    task automatic op_b(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [15:0] got, output int lat);
        @(negedge CLK);
        b_mx = a; b_my = b; b_sgn = s; b_in_valid = 1;
        @(posedge CLK); #1 b_in_valid = 0;
        lat = 0;
        while (!b_out_valid && lat < 100) begin
            @(posedge CLK); #1 lat++;
        end
        got = b_prod;
        @(negedge CLK); b_out_ready = 1;
        @(posedge CLK); #1 b_out_ready = 0;
    endtask

    function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
        return s ? 64'(longint'($signed(a)) * longint'($signed(b))) : {32'b0, a} * {32'b0, b};
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        return s ? 16'(int'($signed(a)) * int'($signed(b))) : 16'(int'(a) * int'(b));
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got, exp;
        logic [15:0] got_b;
        logic [31:0] a, b;
        logic [7:0] a8, b8;
        logic s;
        int lat, t;
        tbl[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
        tbl[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
        tbl[2]  = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000};
        tbl[3]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
        tbl[4]  = '{32'h00000000, 32'h12345678, 1'b0, 64'h0000000000000000};
        tbl[5]  = '{32'h00000003, 32'h00000005, 1'b0, 64'h000000000000000F};
        tbl[6]  = '{32'hFFFFFFFE, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFFA};
        tbl[7]  = '{32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000};
        tbl[8]  = '{32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000};
        tbl[9]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF00000001};
        tbl[10] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 64'h00000000FFFFFFFF};
        tbl[11] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 64'hFFFFFFFFFFFFFFFF};

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_product", product, 0);
        @(negedge CLK) RST = 0;

        for (int i = 0; i < 12; i++) begin
            op(tbl[i].a, tbl[i].b, tbl[i].s, i % 3, got, lat);
            chk($sformatf("vec%0d", i), got, tbl[i].p);
            chk($sformatf("vec%0d_lat", i), lat, 17);
        end

        // Backpressure in DONE with a competing request that must be ignored.
        exp = 64'h000000075B5B5B5B / 64'h1 - 64'h000000075B5B5B5B + 64'h12345 * 64'h6789;
        @(negedge CLK);
        mx = 32'h12345; my = 32'h6789; is_signed = 0; in_valid = 1;
        @(posedge CLK); #1 in_valid = 0;
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge CLK); #1 t++;
        end
        chk("bp_lat", t, 17);
        @(negedge CLK);
        mx = 32'hDEADBEEF; my = 32'hCAFEF00D; is_signed = 1; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            chk("bp_product", product, exp);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        @(negedge CLK); in_valid = 0; out_ready = 1;
        @(posedge CLK); #1 out_ready = 0;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);
        repeat (20) @(posedge CLK);
        #1 chk("bp_no_ghost_op", out_valid, 0);

        // Asynchronous reset during the third RUN cycle.
        @(negedge CLK);
        mx = 32'hFFFFFFFF; my = 32'h2; is_signed = 0; in_valid = 1;
        @(posedge CLK); #1 in_valid = 0;
        repeat (3) @(posedge CLK);
        #1 RST = 1;
        #1;
        chk("midrun_in_ready", in_ready, 1);
        chk("midrun_out_valid", out_valid, 0);
        chk("midrun_product", product, 0);
        @(negedge CLK) RST = 0;
        repeat (20) @(posedge CLK);
        #1 chk("midrun_no_pulse", out_valid, 0);
        op(32'd3, 32'd5, 1'b0, 0, got, lat);
        chk("after_rst_prod", got, 64'd15);
        chk("after_rst_lat", lat, 17);

        // Stepped/random sweep with random consumer gaps.
        for (int i = 0; i < 30; i++) begin
            a = 32'(i) * 32'd143165577 + 32'(i) * 32'd10000;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            op(a, b, s, $urandom_range(0, 3), got, lat);
            chk($sformatf("sweep%0d", i), got, ref32(a, b, s));
            chk($sformatf("sweep%0d_lat", i), lat, 17);
        end

        // Narrow instance, PPC=2: C = ceil(5/2) = 3, last cycle has a masked digit.
        op_b(8'hFF, 8'hFF, 1'b0, got_b, lat);
        chk("b_ff_u", got_b, 16'hFE01);
        chk("b_lat", lat, 3);
        op_b(8'hFF, 8'hFF, 1'b1, got_b, lat);
        chk("b_ff_s", got_b, 16'h0001);
        op_b(8'h80, 8'h80, 1'b1, got_b, lat);
        chk("b_80_s", got_b, 16'h4000);
        op_b(8'h7F, 8'h80, 1'b1, got_b, lat);
        chk("b_7f80_s", got_b, 16'hC080);
        for (int i = 0; i < 80; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            s = 1'($urandom_range(0, 1));
            op_b(a8, b8, s, got_b, lat);
            chk($sformatf("b_rand%0d", i), got_b, ref8(a8, b8, s));
            chk($sformatf("b_rand%0d_lat", i), lat, 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/booth_r4_seq_mult.md
# booth_r4_seq_mult

Parametrised, multi-cycle radix-4 Booth multiplier. It generalises the fixed 32-bit Booth multiplier to any even operand width, a selectable number of partial products per cycle, and per-operation signed or unsigned mode. It uses a valid/ready handshake on both input and output. It sits in the multiplier datapath wherever a full 2W-bit product is needed and area matters more than throughput.

## Interface
- `W`, default 32: operand width; even, ≥ 4.
- `PPC`, default 1: Booth partial products accumulated per cycle; 1 ≤ PPC ≤ W/2+1.
- `CLK` in, 1: clock; all state updates on the rising edge.
- `RST` in, 1: asynchronous, active-high reset.
- `in_valid` in, 1: operands and mode are valid.
- `in_ready` out, 1: block can accept an operation.
- `mx` in, W: multiplicand.
- `my` in, W: multiplier.
- `is_signed` in, 1: 1 means two's-complement operands, 0 means unsigned.
- `out_valid` out, 1: `product` is valid.
- `out_ready` in, 1: consumer accepts `product`.
- `product` out, 2W: exact `mx*my`, interpreted per the latched `is_signed`.

## Operation
- Operand extension: both operands are extended to W+2 bits. In signed mode this is sign extension; in unsigned mode it is zero extension. This gives N = W/2+1 Booth digits.
- Digit i is taken from bits {y[2i+1], y[2i], y[2i-1]}, with y[-1]=0. Each digit is in {−2,−1,0,+1,+2}.
- Partial product for digit i is `digit × mx_ext`, shifted left by 2i. It is added into a (2W+2)-bit accumulator. Negation is two's complement, done by invert plus carry-in.
- `product` = `acc[2W-1:0]`. The result is exact for all inputs in both modes.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid&&in_ready`, latch the extended `mx`, `my` and `is_signed`, clear the accumulator and the digit counter, then go to RUN.
  - RUN: each cycle adds PPC consecutive digits. Digit indices ≥ N contribute 0. After C = ceil(N/PPC) RUN cycles, go to DONE.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- `in_ready` is 0 in RUN and DONE. Inputs presented then are ignored and do not corrupt the operation in flight.
- While `out_valid`=1 and `out_ready`=0, `product` and `out_valid` hold stable.
- `product` holds its last value in IDLE and RUN; only `out_valid` qualifies it.
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `product`=0, accumulator=0, counter=0.
- Reset mid-RUN or mid-DONE abandons the operation immediately. No `out_valid` pulse follows.

## Timing
- Operation accepted at edge k means `out_valid` rises after edge k+C.
  - W=32, PPC=1: C=17.
  - W=32, PPC=4: C=5.
- Handshake in DONE at edge m means IDLE with `in_ready`=1 after edge m. The earliest next accept is edge m+1.
- Minimum occupancy per operation: C+2 cycles.
- The critical path is PPC Booth-select stages plus a (2W+2)-bit adder tree of depth ceil(log2(PPC+1)). Raising PPC trades latency for clock rate.
- `in_ready` and `out_valid` are decoded directly from state registers, with no combinational path from inputs.

## Structure
- Package `booth_pkg`: digit encoding typedef (`BD_ZERO`, `BD_P1`, `BD_P2`, `BD_M1`, `BD_M2`), FSM state enum, and function `n_digits(W)` = W/2+1.
- Sub-module `booth_r4_pp`: combinational block taking a 3-bit window and `mx_ext`. It returns the encoded digit and the (2W+2)-bit unshifted partial product with negation applied. It is instantiated PPC times.
- Top level: FSM, operand and mode latches, digit counter, shift alignment, accumulator, output register.

## Test plan
- W=32, PPC=1, unsigned: `0xFFFFFFFF`×`0xFFFFFFFF` → `0xFFFFFFFE00000001`. `out_valid` must rise exactly 17 cycles after accept.
- W=32, signed:
  - `0xFFFFFFFF`×`0xFFFFFFFF` → `0x0000000000000001`.
  - `0x7FFFFFFF`×`0x80000000` → `0xC000000080000000`.
  - `0x80000000`×`0x80000000` → `0x4000000000000000`.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE. `product` and `out_valid` must stay stable, `in_ready` must stay 0, and a concurrent `in_valid` with new operands must be ignored.
- Reset mid-RUN (cycle 3 of 17): outputs return to reset values immediately. A subsequent operation `3`×`5` → `15` with correct latency.
- Randomised and stepped sweep (mx, my stepping by 10000 across 32-bit range, random `is_signed`, random `out_ready` gaps). Compare against a `$signed`/`$unsigned` reference model; zero mismatches allowed. Run at W∈{4,16,32,64} and PPC∈{1,2,3,W/2+1}, checking latency = ceil((W/2+1)/PPC).
